// File: rtl/decode_ctrl_branch.sv
// Decode stage: latches fetched pc/inst, decodes control, ALU op and immediate,
// and resolves branches/jumps against forwarded operands.
module decode_ctrl_branch (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_rd1,
    input  logic [31:0] i_rd2,
    output logic [4:0]  o_ra1,
    output logic [4:0]  o_ra2,
    output logic [31:0] o_pc,
    output logic [4:0]  o_sa,
    output logic [31:0] o_num,
    output logic [3:0]  o_ALUop,
    output logic        o_sA1,
    output logic        o_sB,
    output logic        o_swd,
    output logic        o_link,
    output logic [4:0]  o_wra,
    output logic        o_regWe,
    output logic        o_dMemWe,
    output logic        o_isLoad,
    output logic        o_taken,
    output logic [31:0] o_next_pc,
    output logic        o_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,
        ALU_OR   = 4'd3,  ALU_XOR = 4'd4,  ALU_NOR = 4'd5,
        ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
        ALU_SRL  = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11
    } aluop_e;

    logic [31:0] pc_q, inst_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else if (i_flush) begin
            pc_q   <= '0;
            inst_q <= '0;
        end else if (!i_stall) begin
            pc_q   <= i_pc;
            inst_q <= i_inst;
        end
    end

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd;
    logic [31:0] pc4, sext, zext, br_tgt, j_tgt;
    logic        rd1_le0;

    assign op      = inst_q[31:26];
    assign funct   = inst_q[5:0];
    assign rt      = inst_q[20:16];
    assign rd      = inst_q[15:11];
    assign pc4     = pc_q + 32'd4;
    assign sext    = {{16{inst_q[15]}}, inst_q[15:0]};
    assign zext    = {16'h0, inst_q[15:0]};
    assign br_tgt  = pc4 + {sext[29:0], 2'b00};
    assign j_tgt   = {pc4[31:28], inst_q[25:0], 2'b00};
    assign rd1_le0 = i_rd1[31] | (i_rd1 == 32'd0);

    aluop_e      alu;
    logic        sA1, sB, swd, link, we, dwe, ld, cond, ill;
    logic [4:0]  wra;
    logic [31:0] num, tgt;

    always_comb begin
        alu  = ALU_ADD;
        sA1  = 1'b0;
        sB   = 1'b0;
        swd  = 1'b0;
        link = 1'b0;
        we   = 1'b0;
        dwe  = 1'b0;
        ld   = 1'b0;
        cond = 1'b0;
        ill  = 1'b0;
        wra  = 5'd0;
        num  = 32'd0;
        tgt  = pc4;
        case (op)
            6'h00: begin
                wra = rd;
                we  = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu = ALU_ADD;
                    6'h22, 6'h23: alu = ALU_SUB;
                    6'h24: alu = ALU_AND;
                    6'h25: alu = ALU_OR;
                    6'h26: alu = ALU_XOR;
                    6'h27: alu = ALU_NOR;
                    6'h2A: alu = ALU_SLT;
                    6'h2B: alu = ALU_SLTU;
                    6'h00: begin alu = ALU_SLL; sA1 = 1'b1; end
                    6'h02: begin alu = ALU_SRL; sA1 = 1'b1; end
                    6'h03: begin alu = ALU_SRA; sA1 = 1'b1; end
                    6'h08: begin we = 1'b0; cond = 1'b1; tgt = i_rd1; end
                    default: ill = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = sext;
            end
            6'h0A: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = sext; alu = ALU_SLT;
            end
            6'h0B: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = sext; alu = ALU_SLTU;
            end
            6'h0C: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = zext; alu = ALU_AND;
            end
            6'h0D: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = zext; alu = ALU_OR;
            end
            6'h0E: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = zext; alu = ALU_XOR;
            end
            6'h0F: begin
                wra = rt; we = 1'b1; sB = 1'b1; alu = ALU_LUI;
                num = {inst_q[15:0], 16'h0};
            end
            6'h23: begin
                wra = rt; we = 1'b1; sB = 1'b1; num = sext;
                ld  = 1'b1; swd = 1'b1;
            end
            6'h2B: begin
                sB = 1'b1; num = sext; dwe = 1'b1;
            end
            6'h04: begin cond = (i_rd1 == i_rd2); tgt = br_tgt; end
            6'h05: begin cond = (i_rd1 != i_rd2); tgt = br_tgt; end
            6'h06: begin cond = rd1_le0;          tgt = br_tgt; end
            6'h07: begin cond = !rd1_le0;         tgt = br_tgt; end
            6'h02: begin cond = 1'b1; tgt = j_tgt; end
            6'h03: begin
                cond = 1'b1; tgt = j_tgt;
                wra  = 5'd31; we = 1'b1; link = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal encodings must not leak any partially decoded control
        if (ill) begin
            alu  = ALU_ADD;
            sA1  = 1'b0;
            sB   = 1'b0;
            swd  = 1'b0;
            link = 1'b0;
            we   = 1'b0;
            dwe  = 1'b0;
            ld   = 1'b0;
            cond = 1'b0;
            wra  = 5'd0;
            num  = 32'd0;
        end
    end

    assign o_ra1     = inst_q[25:21];
    assign o_ra2     = rt;
    assign o_pc      = pc_q;
    assign o_sa      = inst_q[10:6];
    assign o_num     = num;
    assign o_ALUop   = alu;
    assign o_sA1     = sA1;
    assign o_sB      = sB;
    assign o_swd     = swd;
    assign o_link    = link;
    assign o_wra     = wra;
    assign o_regWe   = we & (wra != 5'd0);
    assign o_dMemWe  = dwe;
    assign o_isLoad  = ld;
    assign o_taken   = cond & ~i_stall;
    assign o_next_pc = o_taken ? tgt : pc4;
    assign o_illegal = ill;

endmodule

// File: tb/tb_decode_ctrl_branch.sv
// Directed plus randomized checks of decode_ctrl_branch against a
// mnemonic-level reference model.
module tb_decode_ctrl_branch;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_pc, i_inst, i_rd1, i_rd2;
    logic        i_stall, i_flush;
    logic [4:0]  o_ra1, o_ra2, o_sa, o_wra;
    logic [31:0] o_pc, o_num, o_next_pc;
    logic [3:0]  o_ALUop;
    logic        o_sA1, o_sB, o_swd, o_link, o_regWe, o_dMemWe, o_isLoad;
    logic        o_taken, o_illegal;

    int checks = 0;
    int failures = 0;
    logic [31:0] mpc, minst;
    logic [31:0] hold_pc;

    decode_ctrl_branch dut (
        .clk(clk), .rstn(rstn),
        .i_pc(i_pc), .i_inst(i_inst),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_rd1(i_rd1), .i_rd2(i_rd2),
        .o_ra1(o_ra1), .o_ra2(o_ra2), .o_pc(o_pc), .o_sa(o_sa),
        .o_num(o_num), .o_ALUop(o_ALUop), .o_sA1(o_sA1), .o_sB(o_sB),
        .o_swd(o_swd), .o_link(o_link), .o_wra(o_wra),
        .o_regWe(o_regWe), .o_dMemWe(o_dMemWe), .o_isLoad(o_isLoad),
        .o_taken(o_taken), .o_next_pc(o_next_pc), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, num, nxt;
        logic [4:0]  ra1, ra2, sa, wra;
        logic [3:0]  alu;
        logic        sA1, sB, swd, link, we, dwe, ld, taken, ill;
    } exp_t;

    function automatic string mnem(logic [31:0] inst);
        int op = int'(inst >> 26);
        int fn = int'(inst & 32'h3F);
        if (op == 0) begin
            case (fn)
                'h20: return "add";  'h21: return "addu";
                'h22: return "sub";  'h23: return "subu";
                'h24: return "and";  'h25: return "or";
                'h26: return "xor";  'h27: return "nor";
                'h2A: return "slt";  'h2B: return "sltu";
                'h00: return "sll";  'h02: return "srl";
                'h03: return "sra";  'h08: return "jr";
                default: return "ill";
            endcase
        end
        case (op)
            'h08: return "addi"; 'h09: return "addiu";
            'h0A: return "slti"; 'h0B: return "sltiu";
            'h0C: return "andi"; 'h0D: return "ori";
            'h0E: return "xori"; 'h0F: return "lui";
            'h23: return "lw";   'h2B: return "sw";
            'h04: return "beq";  'h05: return "bne";
            'h06: return "blez"; 'h07: return "bgtz";
            'h02: return "j";    'h03: return "jal";
            default: return "ill";
        endcase
    endfunction

    function automatic int alu_code(string m);
        case (m)
            "add", "addu", "addi", "addiu": return 0;
            "sub", "subu": return 1;
            "and", "andi": return 2;
            "or", "ori":   return 3;
            "xor", "xori": return 4;
            "nor":         return 5;
            "slt", "slti": return 6;
            "sltu", "sltiu": return 7;
            "sll": return 8;
            "srl": return 9;
            "sra": return 10;
            "lui": return 11;
            default: return -1;
        endcase
    endfunction

    function automatic exp_t model(logic [31:0] pc, logic [31:0] inst,
                                   logic [31:0] rd1, logic [31:0] rd2,
                                   logic stall);
        exp_t e;
        string m = mnem(inst);
        int a = alu_code(m);
        int op = int'(inst >> 26);
        logic [31:0] pc4 = pc + 32'd4;
        logic [31:0] imm = inst & 32'hFFFF;
        logic [31:0] sx = (imm >= 32'h8000) ? imm - 32'h10000 : imm;
        logic [31:0] tgt = pc4;
        bit redir = 0;
        bit wr = 0;
        e.pc = pc; e.ra1 = 5'(inst >> 21); e.ra2 = 5'(inst >> 16);
        e.sa = 5'(inst >> 6);
        e.num = 0; e.wra = 0; e.alu = 0;
        e.sA1 = 0; e.sB = 0; e.swd = 0; e.link = 0;
        e.dwe = 0; e.ld = 0; e.ill = 0;
        if (a >= 0 && op == 0) begin
            wr = 1; e.wra = 5'(inst >> 11); e.alu = 4'(a);
            e.sA1 = (m == "sll" || m == "srl" || m == "sra");
        end else if (a >= 0) begin
            wr = 1; e.wra = 5'(inst >> 16); e.alu = 4'(a); e.sB = 1;
            if (m == "andi" || m == "ori" || m == "xori") e.num = imm;
            else if (m == "lui") e.num = imm * 32'h10000;
            else e.num = sx;
        end else if (m == "lw" || m == "sw") begin
            e.sB = 1; e.num = sx;
            if (m == "lw") begin
                wr = 1; e.wra = 5'(inst >> 16); e.ld = 1; e.swd = 1;
            end else e.dwe = 1;
        end else if (m == "jr") begin
            e.wra = 5'(inst >> 11); redir = 1; tgt = rd1;
        end else if (m == "j" || m == "jal") begin
            redir = 1;
            tgt = (pc4 & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
            if (m == "jal") begin wr = 1; e.wra = 31; e.link = 1; end
        end else if (m == "ill") begin
            e.ill = 1;
        end else begin
            tgt = pc4 + sx * 4;
            case (m)
                "beq":  redir = (rd1 == rd2);
                "bne":  redir = (rd1 != rd2);
                "blez": redir = ($signed(rd1) <= 0);
                default: redir = ($signed(rd1) > 0);
            endcase
        end
        e.we = wr && (e.wra != 0);
        e.taken = redir && !stall;
        e.nxt = e.taken ? tgt : pc4;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        exp_t e = model(mpc, minst, i_rd1, i_rd2, i_stall);
        chk({tag, ".pc"},    o_pc,      e.pc);
        chk({tag, ".ra1"},   32'(o_ra1), 32'(e.ra1));
        chk({tag, ".ra2"},   32'(o_ra2), 32'(e.ra2));
        chk({tag, ".sa"},    32'(o_sa),  32'(e.sa));
        chk({tag, ".num"},   o_num,     e.num);
        chk({tag, ".alu"},   32'(o_ALUop), 32'(e.alu));
        chk({tag, ".sA1"},   32'(o_sA1), 32'(e.sA1));
        chk({tag, ".sB"},    32'(o_sB),  32'(e.sB));
        chk({tag, ".swd"},   32'(o_swd), 32'(e.swd));
        chk({tag, ".link"},  32'(o_link), 32'(e.link));
        chk({tag, ".wra"},   32'(o_wra), 32'(e.wra));
        chk({tag, ".we"},    32'(o_regWe), 32'(e.we));
        chk({tag, ".dwe"},   32'(o_dMemWe), 32'(e.dwe));
        chk({tag, ".ld"},    32'(o_isLoad), 32'(e.ld));
        chk({tag, ".taken"}, 32'(o_taken), 32'(e.taken));
        chk({tag, ".next"},  o_next_pc, e.nxt);
        chk({tag, ".ill"},   32'(o_illegal), 32'(e.ill));
    endtask

    task automatic step(input logic [31:0] pc, input logic [31:0] inst,
                        input logic st, input logic fl,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input string tag);
        i_pc = pc; i_inst = inst; i_stall = st; i_flush = fl;
        i_rd1 = r1; i_rd2 = r2;
        @(posedge clk);
        #1;
        if (fl) begin mpc = 0; minst = 0; end
        else if (!st) begin mpc = pc; minst = inst; end
        compare_all(tag);
    endtask

    task automatic rand_inst(output logic [31:0] inst);
        int ops[20] = '{0, 0, 0, 2, 3, 4, 5, 6, 7, 8,
                        9, 10, 11, 12, 13, 14, 15, 35, 43, 63};
        int fns[17] = '{0, 2, 3, 8, 'h20, 'h21, 'h22, 'h23, 'h24,
                        'h25, 'h26, 'h27, 'h2A, 'h2B, 1, 'h09, 'h3F};
        logic [5:0] op = 6'(ops[$urandom_range(0, 19)]);
        logic [5:0] fn = 6'(fns[$urandom_range(0, 16)]);
        logic [19:0] mid = 20'($urandom);
        if ($urandom_range(0, 9) == 0) inst = $urandom;
        else inst = {op, mid, fn};
    endtask

    initial begin
        logic [31:0] ri, r1, r2;
        rstn = 1'b0;
        i_pc = 0; i_inst = 0; i_stall = 0; i_flush = 0;
        i_rd1 = 0; i_rd2 = 0;
        mpc = 0; minst = 0;
        #12;
        compare_all("reset");
        chk("reset_next", o_next_pc, 32'h4);
        chk("reset_alu", 32'(o_ALUop), 32'd8);
        @(negedge clk);
        rstn = 1'b1;

        step(32'h100, 32'h1022FFFF, 0, 0, 5, 5, "beq_t");
        chk("beq_taken", 32'(o_taken), 32'd1);
        chk("beq_target", o_next_pc, 32'h100);

        #2;
        rstn = 1'b0;
        #1;
        mpc = 0; minst = 0;
        compare_all("async_rst");
        chk("async_rst_next", o_next_pc, 32'h4);
        chk("async_rst_sA1", 32'(o_sA1), 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        step(32'h100, 32'h1022FFFF, 0, 0, 5, 6, "beq_nt");
        chk("beq_nt_taken", 32'(o_taken), 32'd0);
        chk("beq_nt_next", o_next_pc, 32'h104);
        step(32'h100, 32'h1022FFFF, 0, 0, 5, 5, "beq_t2");
        step(32'h300, 32'h3C05FFFF, 1, 0, 5, 5, "beq_stall");
        chk("beq_stall_taken", 32'(o_taken), 32'd0);
        chk("beq_stall_pc", o_pc, 32'h100);

        step(32'h10, 32'h34038000, 0, 0, 0, 0, "ori");
        chk("ori_num", o_num, 32'h0000_8000);
        chk("ori_wra", 32'(o_wra), 32'd3);
        chk("ori_we", 32'(o_regWe), 32'd1);
        step(32'h14, 32'h20048000, 0, 0, 0, 0, "addi");
        chk("addi_num", o_num, 32'hFFFF_8000);
        step(32'h18, 32'h3C051234, 0, 0, 0, 0, "lui");
        chk("lui_num", o_num, 32'h1234_0000);
        chk("lui_alu", 32'(o_ALUop), 32'd11);
        step(32'hF000_0000, 32'h0C000010, 0, 0, 0, 0, "jal");
        chk("jal_next", o_next_pc, 32'hF000_0040);
        chk("jal_wra", 32'(o_wra), 32'd31);
        chk("jal_link", 32'(o_link), 32'd1);
        chk("jal_we", 32'(o_regWe), 32'd1);
        step(32'h40, 32'h03E00008, 0, 0, 32'h80, 0, "jr");
        chk("jr_taken", 32'(o_taken), 32'd1);
        chk("jr_next", o_next_pc, 32'h80);
        step(32'h44, 32'h00220020, 0, 0, 1, 2, "add0");
        chk("add0_we", 32'(o_regWe), 32'd0);
        step(32'h48, 32'hFC000000, 0, 0, 1, 1, "illop");
        chk("ill_flag", 32'(o_illegal), 32'd1);
        chk("ill_en", {29'd0, o_regWe, o_dMemWe, o_isLoad}, 32'd0);
        step(32'hFFFF_FFFC, 32'h08000000, 0, 0, 0, 0, "wrap");
        chk("wrap_next", o_next_pc, 32'h0);

        step(32'h50, 32'h34038000, 0, 0, 0, 0, "pre_fl");
        step(32'h200, 32'h34038000, 1, 1, 0, 0, "flush_stall");
        chk("flush_pc", o_pc, 32'h0);
        chk("flush_alu", 32'(o_ALUop), 32'd8);

        step(32'h60, 32'h10000003, 0, 0, 7, 7, "pre_hold");
        hold_pc = 32'h60;
        for (int k = 0; k < 3; k++) begin
            step(32'h70 + 32'(k * 4), 32'h2400FFFF, 1, 0,
                 $urandom, $urandom, "hold");
            chk("hold_pc", o_pc, hold_pc);
            chk("hold_taken", 32'(o_taken), 32'd0);
        end

        for (int n = 0; n < 300; n++) begin
            rand_inst(ri);
            r1 = $urandom;
            case ($urandom_range(0, 5))
                0: r1 = 0;
                1: r1 = 32'($urandom_range(0, 3)) - 32'd1;
                default: ;
            endcase
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            step({$urandom, 2'b00} >> 0, ri,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 r1, r2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
